// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the memory stage.
//   - bit positions inside the 8-bit execute->memory control bundle
//   - access size encodings
//   - FSM state type and state constants
//   - is_misaligned(): alignment rule shared by the FSM and the lane aligner
package mips_pkg;

    // Control bundle bit positions
    localparam int unsigned BitRegWrite = 7;
    localparam int unsigned BitMemToReg = 6;
    localparam int unsigned BitLink     = 5;
    localparam int unsigned BitMemRead  = 4;
    localparam int unsigned BitMemWrite = 3;
    localparam int unsigned BitSizeHi   = 2;
    localparam int unsigned BitSizeLo   = 1;
    localparam int unsigned BitLoadUns  = 0;

    // Access size encodings (2'b11 is unused and treated as a word)
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    // FSM state type
    typedef logic [0:0] state_t;
    localparam state_t StIdle = 1'b0;
    localparam state_t StReq  = 1'b1;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic result;
        case (size)
            SizeByte: result = 1'b0;
            SizeHalf: result = addr_lo[0];
            default:  result = (addr_lo != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational big-endian byte-lane logic for the memory stage.
// Ports:
//   size_i          access size (byte/half/word)
//   addr_lo_i       address bits [1:0]
//   load_unsigned_i zero-extend (1) or sign-extend (0) sub-word loads
//   store_data_i    raw store data from the register file
//   load_word_i     full word returned by memory
//   be_o            byte enables, be_o[3] is the byte at offset 0 (bits 31:24)
//   wdata_o         store data replicated across all lanes
//   load_data_o     addressed lane extracted and extended to 32 bits
//   misaligned_o    access violates its natural alignment
module mem_align
    import mips_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        load_unsigned_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o,
    output logic        misaligned_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign misaligned_o = is_misaligned(size_i, addr_lo_i);

    always_comb begin
        be_o        = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = load_word_i;
        lane_byte   = 8'h00;
        lane_half   = 16'h0000;
        case (size_i)
            SizeByte: begin
                be_o    = 4'b1000 >> addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
                case (addr_lo_i)
                    2'b00:   lane_byte = load_word_i[31:24];
                    2'b01:   lane_byte = load_word_i[23:16];
                    2'b10:   lane_byte = load_word_i[15:8];
                    default: lane_byte = load_word_i[7:0];
                endcase
                load_data_o = load_unsigned_i ? {24'h000000, lane_byte}
                                              : {{24{lane_byte[7]}}, lane_byte};
            end
            SizeHalf: begin
                be_o      = addr_lo_i[1] ? 4'b0011 : 4'b1100;
                wdata_o   = {2{store_data_i[15:0]}};
                lane_half = addr_lo_i[1] ? load_word_i[15:0] : load_word_i[31:16];
                load_data_o = load_unsigned_i ? {16'h0000, lane_half}
                                              : {{16{lane_half[15]}}, lane_half};
            end
            default: begin
                be_o        = 4'b1111;
                wdata_o     = store_data_i;
                load_data_o = load_word_i;
            end
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MIPS-style memory pipeline stage with a two-state request FSM.
// Instructions are captured every cycle while IDLE. Aligned loads/stores move to
// REQ, which holds the bus request and stalls upstream until mem_ack.
// Misaligned accesses never reach the bus; they pulse addr_err instead.
// Optional feature macro: MEM_TIMEOUT_EN adds a 255-cycle request timeout that
// pulses bus_err and suppresses writeback; otherwise REQ waits indefinitely.
// Ports:
//   clk, reset (async, active low)
//   bundle_in, pc_seq_in, alu_in, reg_read2_in, reg_write_dest_in : from execute
//   stall_out : hold upstream while a request is outstanding
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_ack, mem_rdata : memory bus
//   wb_reg_write, wb_dest, wb_data : writeback
//   addr_err, bus_err : error pulses
module memory_stage
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bundle_in,
    input  logic [31:0] pc_seq_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] reg_read2_in,
    input  logic [4:0]  reg_write_dest_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_reg_write,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        addr_err,
    output logic        bus_err
);

    state_t      state_q, state_d;
    logic [7:0]  bundle_q;
    logic [31:0] pc_seq_q;
    logic [31:0] alu_q;
    logic [31:0] store_q;
    logic [4:0]  dest_q;
    logic [31:0] rdata_q;

    logic        capture;
    logic        in_mem_op;
    logic        in_misaligned;
    logic        timeout;

    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        align_misaligned;

    assign capture   = (state_q == StIdle);
    assign in_mem_op = bundle_in[BitMemRead] | bundle_in[BitMemWrite];
    // Checked on the incoming instruction so a bad access never enters REQ.
    assign in_misaligned = is_misaligned(bundle_in[BitSizeHi:BitSizeLo], alu_in[1:0]);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] timer_q, timer_d;
    logic       bus_err_q, bus_err_d;

    // timer_q counts completed REQ cycles; 254 means this is the 255th.
    assign timeout = (timer_q == 8'd254);

    always_comb begin
        timer_d   = 8'd0;
        bus_err_d = 1'b0;
        if (state_q == StReq && !mem_ack) begin
            if (timeout) begin
                bus_err_d = 1'b1;
            end else begin
                timer_d = timer_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q   <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (in_mem_op && !in_misaligned) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (mem_ack || timeout) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            bundle_q <= 8'h00;
            pc_seq_q <= 32'h0;
            alu_q    <= 32'h0;
            store_q  <= 32'h0;
            dest_q   <= 5'd0;
            rdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                bundle_q <= bundle_in;
                pc_seq_q <= pc_seq_in;
                alu_q    <= alu_in;
                store_q  <= reg_read2_in;
                dest_q   <= reg_write_dest_in;
            end
            if (state_q == StReq && mem_ack) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    mem_align u_mem_align (
        .size_i          (bundle_q[BitSizeHi:BitSizeLo]),
        .addr_lo_i       (alu_q[1:0]),
        .load_unsigned_i (bundle_q[BitLoadUns]),
        .store_data_i    (store_q),
        .load_word_i     (rdata_q),
        .be_o            (align_be),
        .wdata_o         (align_wdata),
        .load_data_o     (align_load),
        .misaligned_o    (align_misaligned)
    );

    always_comb begin
        stall_out = (state_q == StReq);
        mem_req   = (state_q == StReq);
        mem_we    = mem_req & bundle_q[BitMemWrite];
        mem_be    = mem_req ? align_be : 4'b0000;
        mem_addr  = {alu_q[31:2], 2'b00};
        mem_wdata = align_wdata;

        // Lasts exactly the one IDLE cycle that holds the offending instruction.
        addr_err = (state_q == StIdle) & align_misaligned
                   & (bundle_q[BitMemRead] | bundle_q[BitMemWrite]);

        wb_reg_write = bundle_q[BitRegWrite] & ~addr_err & ~bus_err;
        wb_dest      = dest_q;
        if (bundle_q[BitLink]) begin
            wb_data = pc_seq_q;
        end else if (bundle_q[BitMemToReg]) begin
            wb_data = align_load;
        end else begin
            wb_data = alu_q;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed steps with a writeback scoreboard.
module tb_memory_stage;

    logic        clk;
    logic        reset;
    logic [7:0]  bundle_in;
    logic [31:0] pc_seq_in;
    logic [31:0] alu_in;
    logic [31:0] reg_read2_in;
    logic [4:0]  reg_write_dest_in;
    logic        stall_out;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        addr_err;
    logic        bus_err;

    memory_stage dut (
        .clk               (clk),
        .reset             (reset),
        .bundle_in         (bundle_in),
        .pc_seq_in         (pc_seq_in),
        .alu_in            (alu_in),
        .reg_read2_in      (reg_read2_in),
        .reg_write_dest_in (reg_write_dest_in),
        .stall_out         (stall_out),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_be            (mem_be),
        .mem_ack           (mem_ack),
        .mem_rdata         (mem_rdata),
        .wb_reg_write      (wb_reg_write),
        .wb_dest           (wb_dest),
        .wb_data           (wb_data),
        .addr_err          (addr_err),
        .bus_err           (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  dest;
        logic [31:0] data;
        logic        chk_data;
        int          stall;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;

    logic        obs_req;
    logic        obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic [31:0] obs_addr;
    logic        obs_aerr;
    logic        mem_stable;
    int          stall_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic expect_wb(input logic wr, input logic [4:0] dest, input logic [31:0] data,
                             input logic chk_data, input int stall);
        exp_t e;
        e.wr       = wr;
        e.dest     = dest;
        e.data     = data;
        e.chk_data = chk_data;
        e.stall    = stall;
        exp_q.push_back(e);
    endtask

    // Independent reference: shift the addressed big-endian lane down, then extend.
    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [1:0] a,
                                             input logic [31:0] w, input logic uns);
        logic [31:0] v;
        int          sh;
        if (size == 2'b00) begin
            sh = 24 - 8 * int'(a);
            v  = (w >> sh) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            sh = 16 - 8 * int'(a);
            v  = (w >> sh) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] tbl_byte [4];
        tbl_byte[0] = 4'b1000;
        tbl_byte[1] = 4'b0100;
        tbl_byte[2] = 4'b0010;
        tbl_byte[3] = 4'b0001;
        if (size == 2'b00) return tbl_byte[a];
        if (size == 2'b01) return (a == 2'b00) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    // Drive one instruction, serve the bus (ack after ack_after REQ cycles, never if < 0),
    // then compare writeback against the scoreboard head.
    task automatic do_op(input logic [7:0] b, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] dest,
                         input int ack_after, input logic [31:0] rdata);
        exp_t e;
        bundle_in         = b;
        pc_seq_in         = pc;
        alu_in            = alu;
        reg_read2_in      = rd2;
        reg_write_dest_in = dest;
        mem_rdata         = rdata;
        @(posedge clk);
        #1;
        bundle_in  = 8'h00;
        obs_req    = mem_req;
        obs_we     = mem_we;
        obs_be     = mem_be;
        obs_wdata  = mem_wdata;
        obs_addr   = mem_addr;
        obs_aerr   = addr_err;
        mem_stable = 1'b1;
        stall_cnt  = 0;
        while (stall_out && stall_cnt < 400) begin
            if (mem_be !== obs_be || mem_wdata !== obs_wdata || mem_addr !== obs_addr ||
                mem_we !== obs_we || mem_req !== 1'b1) begin
                mem_stable = 1'b0;
            end
            if (stall_cnt == ack_after) mem_ack = 1'b1;
            stall_cnt++;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("stall_cycles", 32'(stall_cnt), 32'(e.stall));
            check("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e.wr});
            check("wb_dest", {27'd0, wb_dest}, {27'd0, e.dest});
            if (e.chk_data) check("wb_data", wb_data, e.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  szv;
        logic [1:0]  av;
        logic [7:0]  bv;
        logic [31:0] rd;

        reset             = 1'b0;
        bundle_in         = 8'h00;
        pc_seq_in         = 32'h0;
        alu_in            = 32'h0;
        reg_read2_in      = 32'h0;
        reg_write_dest_in = 5'd0;
        mem_ack           = 1'b0;
        mem_rdata         = 32'h0;

        // Reset state: inputs are non-zero to show reset wins
        bundle_in = 8'hFF;
        alu_in    = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", {31'd0, stall_out}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wb_reg_write", {31'd0, wb_reg_write}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        bundle_in = 8'h00;
        alu_in    = 32'h0;
        reset     = 1'b1;
        @(posedge clk);
        #1;

        // ALU op passes through with no stall
        expect_wb(1'b1, 5'd5, 32'h0000_1234, 1'b1, 0);
        do_op(8'h80, 32'h0000_0044, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
        check("alu_mem_req", {31'd0, obs_req}, 32'd0);

        // Link op writes back the sequential PC
        expect_wb(1'b1, 5'd31, 32'h0000_0200, 1'b1, 0);
        do_op(8'hA0, 32'h0000_0200, 32'h0000_9999, 32'h0, 5'd31, 0, 32'h0);

        // lb at 0x103, ack after 2 cycles
        expect_wb(1'b1, 5'd8, 32'hFFFF_FFF0, 1'b1, 3);
        do_op(8'hD0, 32'h0, 32'h0000_0103, 32'h0, 5'd8, 2, 32'h0000_00F0);
        check("lb_mem_req", {31'd0, obs_req}, 32'd1);
        check("lb_mem_be", {28'd0, obs_be}, 32'h1);
        check("lb_mem_we", {31'd0, obs_we}, 32'd0);
        check("lb_mem_addr", obs_addr, 32'h0000_0100);
        check("lb_stable", {31'd0, mem_stable}, 32'd1);

        // sh at 0x102
        expect_wb(1'b0, 5'd0, 32'h0000_0102, 1'b1, 1);
        do_op(8'h0A, 32'h0, 32'h0000_0102, 32'h0000_ABCD, 5'd0, 0, 32'h0);
        check("sh_mem_we", {31'd0, obs_we}, 32'd1);
        check("sh_mem_be", {28'd0, obs_be}, 32'h3);
        check("sh_mem_wdata", obs_wdata, 32'hABCD_ABCD);

        // sb at 0x101, ack after 3 cycles
        expect_wb(1'b0, 5'd0, 32'h0000_0101, 1'b1, 4);
        do_op(8'h08, 32'h0, 32'h0000_0101, 32'h1234_565A, 5'd0, 3, 32'h0);
        check("sb_mem_be", {28'd0, obs_be}, 32'h4);
        check("sb_mem_wdata", obs_wdata, 32'h5A5A_5A5A);
        check("sb_stable", {31'd0, mem_stable}, 32'd1);

        // sw at 0x200
        expect_wb(1'b0, 5'd0, 32'h0000_0200, 1'b1, 1);
        do_op(8'h0C, 32'h0, 32'h0000_0200, 32'hDEAD_BEEF, 5'd0, 0, 32'h0);
        check("sw_mem_be", {28'd0, obs_be}, 32'hF);
        check("sw_mem_wdata", obs_wdata, 32'hDEAD_BEEF);
        check("sw_mem_addr", obs_addr, 32'h0000_0200);

        // Loads across every aligned lane, signed and unsigned
        for (int sz = 0; sz < 3; sz++) begin
            for (int a = 0; a < 4; a++) begin
                for (int u = 0; u < 2; u++) begin
                    szv = sz[1:0];
                    av  = a[1:0];
                    if ((sz == 1 && av[0]) || (sz == 2 && a != 0)) continue;
                    rd = $urandom;
                    rd[31] = av[0];
                    rd[15] = ~av[0];
                    bv = 8'hD0 | {5'd0, szv, 1'b0} | {7'd0, u[0]};
                    expect_wb(1'b1, 5'd9, ref_load(szv, av, rd, u[0]), 1'b1, 2);
                    do_op(bv, 32'h0, 32'h0000_0800 + 32'(a), 32'h0, 5'd9, 1, rd);
                    check("ld_mem_be", {28'd0, obs_be}, {28'd0, ref_be(szv, av)});
                end
            end
        end

        // Misaligned lw at 0x101: no request, one-cycle addr_err, no writeback
        expect_wb(1'b0, 5'd7, 32'h0, 1'b0, 0);
        do_op(8'hD4, 32'h0, 32'h0000_0101, 32'h0, 5'd7, 0, 32'h0);
        check("lw_mis_addr_err", {31'd0, obs_aerr}, 32'd1);
        check("lw_mis_mem_req", {31'd0, obs_req}, 32'd0);
        @(posedge clk);
        #1;
        check("lw_mis_addr_err_end", {31'd0, addr_err}, 32'd0);

        // Misaligned lh at 0x103
        expect_wb(1'b0, 5'd6, 32'h0, 1'b0, 0);
        do_op(8'hD2, 32'h0, 32'h0000_0103, 32'h0, 5'd6, 0, 32'h0);
        check("lh_mis_addr_err", {31'd0, obs_aerr}, 32'd1);

        // mem_ack while idle is ignored
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("idle_ack_stall", {31'd0, stall_out}, 32'd0);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);

        // Reset in the middle of a request drops it asynchronously
        bundle_in = 8'hD4;
        alu_in    = 32'h0000_0400;
        @(posedge clk);
        #1;
        bundle_in = 8'h00;
        check("mid_req_before", {31'd0, mem_req}, 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("mid_req_drop", {31'd0, mem_req}, 32'd0);
        check("mid_stall_drop", {31'd0, stall_out}, 32'd0);
        check("mid_be_drop", {28'd0, mem_be}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_stall", {31'd0, stall_out}, 32'd0);
        check("post_rst_req", {31'd0, mem_req}, 32'd0);

`ifdef MEM_TIMEOUT_EN
        // lw with no ack times out after 255 REQ cycles
        expect_wb(1'b0, 5'd3, 32'h0, 1'b0, 255);
        do_op(8'hD4, 32'h0, 32'h0000_0300, 32'h0, 5'd3, -1, 32'h0);
        check("to_bus_err", {31'd0, bus_err}, 32'd1);
        check("to_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1;
        check("to_bus_err_end", {31'd0, bus_err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
